max1_mem_ctrl: RTL
==================

MAX1_MEM_CTRL -- requirements
Module: max1_mem_ctrl

Interface
REQ-001 The block SHALL have parameter N_PIX, default 169, meaning pixels per channel of the max-pool 1 result (13x13).
REQ-002 The block SHALL have parameter N_CH, default 3, meaning channels written per beat (fixed: wadd1/wadd2/wadd3).
REQ-003 The block SHALL have parameter ADDR_W, default 10, meaning the result-memory address width.
REQ-004 clk  in  1  Single clock for all logic; one clock, no clk_div path.
REQ-005 rst_n  in  1  Reset, asynchronous assert, active-low.
REQ-006 start  in  1  Pulse that arms a new fill of the result memory.
REQ-007 pool_valid  in  1  Max-pool 1 presents one 3-channel result this cycle.
REQ-008 rd_start  in  1  Consumer (next layer) requests a drain of the full memory.
REQ-009 rd_ready  in  1  Consumer accepts a read this cycle; low stalls the drain.
REQ-010 wen  out  1  Memory write enable.
REQ-011 wadd1, wadd2, wadd3  out  ADDR_W each  Channel 0/1/2 write addresses.
REQ-012 ren  out  1  Memory read enable.
REQ-013 radd  out  ADDR_W  Memory read address.
REQ-014 rd_valid  out  1  Memory rdata is valid this cycle.
REQ-015 full  out  1  All N_PIX*N_CH entries written, drain not yet started.
REQ-016 busy  out  1  FSM not in IDLE.
REQ-017 done  out  1  One-cycle pulse when the last read has been issued.

Function
REQ-018 FSM states SHALL be IDLE, FILL, FULL, DRAIN, DONE.
REQ-019 Transitions: IDLE->FILL on start; FILL->FULL on the N_PIX-th accepted pool_valid; FULL->DRAIN on rd_start; DRAIN->DONE on the cycle issuing radd = N_PIX*N_CH-1; DONE->IDLE unconditionally after 1 cycle.
REQ-020 In FILL, wen SHALL equal pool_valid combinationally, with wadd1 = pix, wadd2 = pix+N_PIX, wadd3 = pix+2*N_PIX, pix = 0..N_PIX-1.
REQ-021 pix SHALL increment by 1 on each accepted beat and SHALL clear to 0 on entering FILL.
REQ-022 pool_valid outside FILL SHALL be ignored (wen=0, no counter change).
REQ-023 Write addresses SHALL never exceed N_PIX*N_CH-1; no wrap occurs, as FILL exits at pix = N_PIX-1.
REQ-024 In DRAIN, ren SHALL equal rd_ready; radd SHALL start at 0 and increment by 1 per cycle with ren=1, reaching N_PIX*N_CH-1 (506 by default).
REQ-025 rd_ready low in DRAIN SHALL hold radd and force ren=0 (stall, no lost address).
REQ-026 rd_valid SHALL be ren delayed by exactly 1 clk (memory read latency 1).
REQ-027 start outside IDLE and rd_start outside FULL SHALL be ignored; rd_start arriving together with the final write SHALL be ignored (it must be re-asserted in FULL).
REQ-028 full SHALL be 1 exactly while in FULL; busy SHALL be 1 in FILL, FULL, DRAIN and DONE.
REQ-029 done SHALL be 1 only in DONE; rd_valid for the last address SHALL coincide with done.
REQ-030 All outputs other than wen, wadd1..3 and ren SHALL be registered.
REQ-031 Address arithmetic SHALL be unsigned ADDR_W-bit; N_PIX*N_CH SHALL be at most 2**ADDR_W, enforced by an elaboration check.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, with pix=0, radd=0, rd_valid=0, full=0, busy=0, done=0, wen=0, ren=0, wadd1=0, wadd2=N_PIX, wadd3=2*N_PIX.
REQ-033 Reset mid-FILL or mid-DRAIN SHALL abandon the operation; no partial-state resume; the next start begins at pix=0.

Structure
REQ-034 A shared package SHALL hold the state encoding typedef, N_PIX/N_CH defaults and the derived constant MEM_DEPTH = N_PIX*N_CH.
REQ-035 One sub-module, addr_counter (loadable, enable, terminal-count flag), SHALL be instantiated twice: once for pix and once for radd.

Verification
REQ-036 Reset then start, 169 back-to-back pool_valid -> wadd1 0..168, wadd2 169..337, wadd3 338..506, full=1 the cycle after the last beat.
REQ-037 FILL with pool_valid toggling 1/0 -> wen follows pool_valid, pix advances only on 1s, still 169 writes total.
REQ-038 FULL, rd_start, rd_ready=1 -> radd 0..506 over 507 cycles, rd_valid lags ren by 1, done pulses once, then IDLE.
REQ-039 DRAIN with rd_ready low for 5 cycles at radd=100 -> radd holds 100, ren=0, resumes at 100 with no skip or duplicate.
REQ-040 Start during DRAIN, pool_valid in IDLE, rd_start in FILL -> all ignored, no wen and no state change.
REQ-041 rst_n low at pix=80 in FILL -> all outputs take reset values immediately; a new start writes from wadd1=0.

Source files
------------

// File: rtl/max1_mem_ctrl_pkg.sv
// Shared definitions for the max-pool 1 result-memory controller:
// FSM state encoding, default geometry and the derived memory depth.
package max1_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_FULL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int N_PIX_DEF  = 169;  // 13x13 pixels per channel
    localparam int N_CH_DEF   = 3;    // channels written per beat
    localparam int ADDR_W_DEF = 10;

    // Total result-memory entries for a given geometry.
    function automatic int mem_depth(input int n_pix, input int n_ch);
        return n_pix * n_ch;
    endfunction

    localparam int MEM_DEPTH = N_PIX_DEF * N_CH_DEF;

endpackage

// File: rtl/max1_mem_ctrl_if.sv
// Bus between the max-pool 1 producer / next-layer consumer (master side)
// and the result-memory controller (slave side).
interface max1_mem_ctrl_if
    import max1_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic              pool_valid;
    logic              rd_start;
    logic              rd_ready;
    logic              wen;
    logic [ADDR_W-1:0] wadd1;
    logic [ADDR_W-1:0] wadd2;
    logic [ADDR_W-1:0] wadd3;
    logic              ren;
    logic [ADDR_W-1:0] radd;
    logic              rd_valid;
    logic              full;
    logic              busy;
    logic              done;

    modport master (
        output start, pool_valid, rd_start, rd_ready,
        input  wen, wadd1, wadd2, wadd3, ren, radd, rd_valid, full, busy, done
    );

    modport slave (
        input  start, pool_valid, rd_start, rd_ready,
        output wen, wadd1, wadd2, wadd3, ren, radd, rd_valid, full, busy, done
    );
endinterface

// File: rtl/max1_mem_ctrl_addr_counter.sv
// Loadable up-counter with enable and a terminal-count flag; used for both
// the fill pixel index and the drain read address.
module addr_counter #(
    parameter int             W    = 10,
    parameter logic [W-1:0]   LAST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         tc
);

    // Count register: load has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= q + W'(1);
        end
    end

    assign tc = (q == LAST);

endmodule

// File: rtl/max1_mem_ctrl.sv
// Result-memory controller behind max-pool 1: fills N_PIX three-channel
// results into a flat memory, then drains it in address order to the
// next layer with back-pressure from rd_ready.
module max1_mem_ctrl
    import max1_mem_ctrl_pkg::*;
#(
    parameter int N_PIX  = N_PIX_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    max1_mem_ctrl_if.slave bus
);

    localparam int                DEPTH     = mem_depth(N_PIX, N_CH);
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(N_PIX - 1);
    localparam logic [ADDR_W-1:0] RADD_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CH1_BASE  = ADDR_W'(N_PIX);
    localparam logic [ADDR_W-1:0] CH2_BASE  = ADDR_W'(2 * N_PIX);

    if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("max1_mem_ctrl: N_PIX*N_CH does not fit in ADDR_W address bits");
    end
    if (N_CH != 3) begin : g_bad_nch
        $error("max1_mem_ctrl: exactly three write channels are supported");
    end

    state_t            state_q, state_d;
    logic              pix_load, pix_en, pix_tc;
    logic              radd_load, radd_en, radd_tc;
    logic [ADDR_W-1:0] pix;
    logic [ADDR_W-1:0] radd;

    addr_counter #(.W(ADDR_W), .LAST(PIX_LAST)) u_pix_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pix_load),
        .load_val ('0),
        .en       (pix_en),
        .q        (pix),
        .tc       (pix_tc)
    );

    addr_counter #(.W(ADDR_W), .LAST(RADD_LAST)) u_radd_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (radd_load),
        .load_val ('0),
        .en       (radd_en),
        .q        (radd),
        .tc       (radd_tc)
    );

    // Channel planes sit back to back; the last pixel never advances the
    // counter, so the top plane stops at DEPTH-1.
    assign bus.wadd1 = pix;
    assign bus.wadd2 = pix + CH1_BASE;
    assign bus.wadd3 = pix + CH2_BASE;
    assign bus.radd  = radd;

    // Next-state, counter control and combinational write/read strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
        pix_load  = 1'b0;
        pix_en    = 1'b0;
        radd_load = 1'b0;
        radd_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_FILL;
                    pix_load = 1'b1;
                end
            end
            ST_FILL: begin
                bus.wen = bus.pool_valid;
                if (bus.pool_valid) begin
                    if (pix_tc) state_d = ST_FULL;
                    else        pix_en  = 1'b1;
                end
            end
            ST_FULL: begin
                if (bus.rd_start) begin
                    state_d   = ST_DRAIN;
                    radd_load = 1'b1;
                end
            end
            ST_DRAIN: begin
                bus.ren = bus.rd_ready;
                if (bus.rd_ready) begin
                    if (radd_tc) state_d = ST_DONE;
                    else         radd_en = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bus.rd_valid <= 1'b0;
            bus.full     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus.rd_valid <= bus.ren;
            bus.full     <= (state_d == ST_FULL);
            bus.busy     <= (state_d != ST_IDLE);
            bus.done     <= (state_d == ST_DONE);
        end
    end

endmodule
